// File: rtl/led_heartbeat.sv
// Multi-channel status LED driver: one shared prescaler tick, per-channel OFF/ON/BLINK/PWM.
// Optional feature macro: LED_PWM_EN builds the PWM phase counter and per-channel duty registers.
module led_heartbeat #(
  parameter int NCH      = 8,
  parameter int TICK_DIV = 50000000,
  parameter int CW       = 16,
  parameter int PW       = 8,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int DW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [1:0]     cfg_mode,
  input  logic [CW-1:0]  cfg_half,
  input  logic [PW-1:0]  cfg_duty,
  output logic [NCH-1:0] led,
  output logic           tick
);

  localparam logic [1:0]    MODE_OFF   = 2'd0;
  localparam logic [1:0]    MODE_ON    = 2'd1;
  localparam logic [1:0]    MODE_BLINK = 2'd2;
  localparam logic [1:0]    MODE_PWM   = 2'd3;
  localparam logic [DW-1:0] DIV_LAST   = DW'(TICK_DIV - 1);

  logic [DW-1:0] presc_reg;
  logic          tick_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg  <= (presc_reg == DIV_LAST);
      presc_reg <= (presc_reg == DIV_LAST) ? '0 : presc_reg + DW'(1);
    end
  end

  assign tick = tick_reg;

`ifdef LED_PWM_EN
  logic [PW-1:0] phase_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_reg + PW'(1);
    end
  end
`else
  logic unused_duty;
  assign unused_duty = ^cfg_duty;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic          hit;
      logic [1:0]    mode_reg;
      logic [CW-1:0] half_reg;
      logic [CW-1:0] cnt_reg;
      logic          led_reg;
      logic [CW:0]   cnt_inc;
      logic [CW:0]   half_min;
      logic          pwm_on;

      // Out-of-range channel numbers match no generate index, so such writes are dropped.
      assign hit      = cfg_we && (cfg_ch == CHW'(gi));
      assign cnt_inc  = {1'b0, cnt_reg} + (CW+1)'(1);
      assign half_min = (half_reg == '0) ? (CW+1)'(1) : {1'b0, half_reg};

`ifdef LED_PWM_EN
      logic [PW-1:0] duty_reg;

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          duty_reg <= '0;
        end else if (hit) begin
          duty_reg <= cfg_duty;
        end
      end

      assign pwm_on = (phase_reg < duty_reg);
`else
      assign pwm_on = 1'b0;
`endif

      // A write takes priority over a coincident tick for this channel only.
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          mode_reg <= MODE_OFF;
          half_reg <= '0;
          cnt_reg  <= '0;
          led_reg  <= 1'b0;
        end else if (hit) begin
          mode_reg <= cfg_mode;
          half_reg <= cfg_half;
          cnt_reg  <= '0;
          led_reg  <= (cfg_mode == MODE_ON);
        end else begin
          case (mode_reg)
            MODE_ON: begin
              led_reg <= 1'b1;
            end
            MODE_BLINK: begin
              if (tick_reg) begin
                if (cnt_inc >= half_min) begin
                  cnt_reg <= '0;
                  led_reg <= ~led_reg;
                end else begin
                  cnt_reg <= cnt_reg + CW'(1);
                end
              end
            end
            MODE_PWM: begin
              led_reg <= pwm_on;
            end
            default: begin
              led_reg <= 1'b0;
            end
          endcase
        end
      end

      assign led[gi] = led_reg;
    end
  endgenerate

endmodule

// File: tb/tb_led_heartbeat.sv
// Self-checking bench for led_heartbeat: table-driven writes plus hand-written timing sequences.
`timescale 1ns/1ps
module tb_led_heartbeat;

  localparam int NCH      = 4;
  localparam int TICK_DIV = 4;
  localparam int CW       = 8;
  localparam int PW       = 8;
`ifdef LED_PWM_EN
  localparam int PWM_BUILT = 1;
`else
  localparam int PWM_BUILT = 0;
`endif

  logic           sys_clk   = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic           cfg_we    = 1'b0;
  logic [1:0]     cfg_ch    = '0;
  logic [1:0]     cfg_mode  = '0;
  logic [CW-1:0]  cfg_half  = '0;
  logic [PW-1:0]  cfg_duty  = '0;
  logic [NCH-1:0] led;
  logic           tick;

  // Second instance with a non-power-of-two channel count so that cfg_ch can address a missing channel.
  logic           cfg_we_b  = 1'b0;
  logic [2:0]     cfg_ch_b  = '0;
  logic [4:0]     led_b;
  logic           tick_b;

  led_heartbeat #(.NCH(NCH), .TICK_DIV(TICK_DIV), .CW(CW), .PW(PW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_duty(cfg_duty), .led(led), .tick(tick)
  );

  led_heartbeat #(.NCH(5), .TICK_DIV(TICK_DIV), .CW(CW), .PW(PW)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we_b), .cfg_ch(cfg_ch_b),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_duty(cfg_duty), .led(led_b), .tick(tick_b)
  );

  always #5 sys_clk = ~sys_clk;

  // Edges since the last reset release; edge k is the k-th rising edge with reset high.
  int edge_n = 0;
  always @(posedge sys_clk) begin
    if (!sys_rst_n) edge_n <= 0;
    else            edge_n <= edge_n + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [1:0]    ch;
    logic [1:0]    mode;
    logic [CW-1:0] half;
    logic [PW-1:0] duty;
    logic [3:0]    exp_led;
  } vec_t;
  vec_t vecs[10];

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] act);
    sb_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty actual=%0h", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s actual=%0h required=%0h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    sb_push(name, exp);
    sb_pop_check(act);
  endtask

  // Called at a falling edge; the write is sampled on the next rising edge (returned as w).
  task automatic do_write(input logic [1:0] ch, input logic [1:0] mode, input logic [CW-1:0] half,
                          input logic [PW-1:0] duty, output int w);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_half = half; cfg_duty = duty;
    w = edge_n + 1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cfg_we = 1'b0;
  endtask

  task automatic write_b(input logic [2:0] ch, input logic [1:0] mode);
    cfg_we_b = 1'b1; cfg_ch_b = ch; cfg_mode = mode; cfg_half = '0; cfg_duty = '0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    cfg_we_b = 1'b0;
  endtask

  task automatic presc_run(input int n, input logic [3:0] exp_led);
    int e;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      e = edge_n;
      check($sformatf("tick_e%0d", e), 32'(tick), 32'((e > 0) && (e % TICK_DIV == 0)));
      check($sformatf("led_e%0d", e), 32'(led), 32'(exp_led));
    end
  endtask

  // Ticks are sampled on edges 5, 9, 13...; the toggle lands on every max(h,1)-th such edge after w.
  task automatic blink_run(input int ch, input int h, input int w, input int n);
    int hh, t1, first, period, e;
    logic [31:0] exp;
    hh = (h == 0) ? 1 : h;
    t1 = w + 1;
    while ((t1 % TICK_DIV) != 1) t1++;
    first  = t1 + TICK_DIV * (hh - 1);
    period = TICK_DIV * hh;
    for (int i = 0; i < n; i++) begin
      e   = edge_n;
      exp = '0;
      if (e >= first) exp[ch] = (((e - first) / period) % 2 == 0);
      check($sformatf("blink_ch%0d_h%0d_e%0d", ch, h, e), 32'(led), exp);
      @(negedge sys_clk);
    end
  endtask

  // Phase after edge e is e mod 256, so led after edge e reflects ((e-1) mod 256) < duty.
  task automatic pwm_run(input int duty, input int w, input int n);
    int e, highs;
    logic [31:0] exp;
    highs = 0;
    for (int i = 0; i < n; i++) begin
      e   = edge_n;
      exp = '0;
      if (PWM_BUILT != 0 && e > w) exp[2] = (((e - 1) % 256) < duty);
      check($sformatf("pwm_d%0d_e%0d", duty, e), 32'(led), exp);
      if (e > w && e <= w + 256 && led[2] === 1'b1) highs++;
      @(negedge sys_clk);
    end
    check($sformatf("pwm_d%0d_count", duty), 32'(highs), 32'((PWM_BUILT != 0) ? duty : 0));
  endtask

  initial begin
    int w;
    bit found;

    vecs[0] = '{ch: 2'd0, mode: 2'd1, half: 8'd0, duty: 8'd0,  exp_led: 4'b0001};
    vecs[1] = '{ch: 2'd1, mode: 2'd1, half: 8'd0, duty: 8'd0,  exp_led: 4'b0011};
    vecs[2] = '{ch: 2'd3, mode: 2'd1, half: 8'd0, duty: 8'd0,  exp_led: 4'b1011};
    vecs[3] = '{ch: 2'd0, mode: 2'd0, half: 8'd0, duty: 8'd0,  exp_led: 4'b1010};
    vecs[4] = '{ch: 2'd1, mode: 2'd2, half: 8'd3, duty: 8'd0,  exp_led: 4'b1000};
    vecs[5] = '{ch: 2'd2, mode: 2'd3, half: 8'd0, duty: 8'd0,  exp_led: 4'b1000};
    vecs[6] = '{ch: 2'd3, mode: 2'd1, half: 8'd0, duty: 8'd0,  exp_led: 4'b1000};
    vecs[7] = '{ch: 2'd3, mode: 2'd0, half: 8'd0, duty: 8'd9,  exp_led: 4'b0000};
    vecs[8] = '{ch: 2'd1, mode: 2'd0, half: 8'd0, duty: 8'd0,  exp_led: 4'b0000};
    vecs[9] = '{ch: 2'd2, mode: 2'd0, half: 8'd0, duty: 8'd0,  exp_led: 4'b0000};

    // Reset state and prescaler cadence
    repeat (3) @(negedge sys_clk);
    check("reset_led",   32'(led),   32'd0);
    check("reset_tick",  32'(tick),  32'd0);
    check("reset_led_b", 32'(led_b), 32'd0);
    sys_rst_n = 1'b1;
    presc_run(16, 4'b0000);

    // Single-edge write latency across modes
    foreach (vecs[i]) begin
      cfg_we = 1'b1; cfg_ch = vecs[i].ch; cfg_mode = vecs[i].mode;
      cfg_half = vecs[i].half; cfg_duty = vecs[i].duty;
      sb_push($sformatf("vec%0d_ch%0d_m%0d", i, vecs[i].ch, vecs[i].mode), 32'(vecs[i].exp_led));
      @(posedge sys_clk);
      @(negedge sys_clk);
      cfg_we = 1'b0;
      sb_pop_check(32'(led));
    end

    // BLINK half=3, then half=0
    do_write(2'd1, 2'd2, 8'd3, 8'd0, w);
    blink_run(1, 3, w, 60);
    do_write(2'd1, 2'd2, 8'd0, 8'd0, w);
    blink_run(1, 0, w, 20);
    do_write(2'd1, 2'd0, 8'd0, 8'd0, w);
    check("blink_off", 32'(led), 32'd0);

    // PWM duty 64, then duty 0
    do_write(2'd2, 2'd3, 8'd0, 8'd64, w);
    pwm_run(64, w, 260);
    do_write(2'd2, 2'd3, 8'd0, 8'd0, w);
    pwm_run(0, w, 260);
    do_write(2'd2, 2'd0, 8'd0, 8'd0, w);

    // Write collides with tick on a lit BLINK channel
    do_write(2'd3, 2'd2, 8'd1, 8'd0, w);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge sys_clk);
      if (tick === 1'b1 && led[3] === 1'b1) found = 1'b1;
    end
    check("collide_setup", 32'(found), 32'd1);
    do_write(2'd3, 2'd2, 8'd2, 8'd0, w);
    check("collide_tick_edge", 32'((w % TICK_DIV) == 1), 32'd1);
    blink_run(3, 2, w, 20);

    // Invalid channel on the five-channel instance
    write_b(3'd0, 2'd1);
    check("inv_on_ch0",  32'(led_b), 32'b00001);
    write_b(3'd5, 2'd1);
    check("inv_ch5",     32'(led_b), 32'b00001);
    write_b(3'd7, 2'd1);
    check("inv_ch7",     32'(led_b), 32'b00001);
    write_b(3'd4, 2'd1);
    check("inv_ch4_top", 32'(led_b), 32'b10001);
    write_b(3'd0, 2'd0);
    check("inv_ch0_off", 32'(led_b), 32'b10000);

    // Asynchronous reset while channels are active
    do_write(2'd0, 2'd1, 8'd0, 8'd0, w);
    do_write(2'd1, 2'd2, 8'd0, 8'd0, w);
    repeat (3) @(negedge sys_clk);
    check("prereset_ch0_on", 32'(led[0]), 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_led",   32'(led),   32'd0);
    check("async_rst_tick",  32'(tick),  32'd0);
    check("async_rst_led_b", 32'(led_b), 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    presc_run(12, 4'b0000);
    check("postreset_led_b", 32'(led_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
